// File: rtl/vga_request_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_request_gen
// Description : VGA 640x480 timing and request/address generator for the
//               colour-tracking datapath. Produces per-line (HRequest),
//               per-frame (VRequest) and active-area (Request) strobes, a
//               20-bit {row,col} ball-RAM address, active-low syncs and
//               start-of-line / start-of-frame pulses.
//
// Ports       : iVgaClk        in   pixel clock
//               iReset_n       in   asynchronous reset, active low
//               iEnable        in   run request, honoured at frame boundary
//               oVgaHRequest   out  hcount inside visible columns
//               oVgaVRequest   out  vcount inside visible lines
//               oVgaRequest    out  visible pixel
//               oPixelAddress  out  {row[9:0],col[9:0]} in visible area, else 0
//               oVgaHS_n       out  horizontal sync, active low
//               oVgaVS_n       out  vertical sync, active low
//               oLineStart     out  pulse on column 0 of a visible line
//               oFrameStart    out  pulse on pixel (0,0)
//               oRunning       out  a frame is being emitted
//
// Build option: VGA_REQ_ADDR_LEAD_EN -- when defined, oPixelAddress carries
//               the address of the *next* pixel so that a RAM with one clock
//               of read latency returns data aligned with oVgaRequest.
//
// Revision    : 1.0 - initial release
// ============================================================================
module vga_request_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        iVgaClk,
    input  logic        iReset_n,
    input  logic        iEnable,
    output logic        oVgaHRequest,
    output logic        oVgaVRequest,
    output logic        oVgaRequest,
    output logic [19:0] oPixelAddress,
    output logic        oVgaHS_n,
    output logic        oVgaVS_n,
    output logic        oLineStart,
    output logic        oFrameStart,
    output logic        oRunning
);

    // ------------------------------------------------------------------
    // Geometry constants (counters are 10 bits wide: totals up to 1024)
    // ------------------------------------------------------------------
    localparam int         c_hTotal    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         c_vTotal    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] c_hActive   = 10'(H_ACTIVE);
    localparam logic [9:0] c_hSyncBeg  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_hSyncEnd  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_hLast     = 10'(c_hTotal - 1);
    localparam logic [9:0] c_vActive   = 10'(V_ACTIVE);
    localparam logic [9:0] c_vSyncBeg  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_vSyncEnd  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] c_vLast     = 10'(c_vTotal - 1);

    // RUN and DRAIN both emit pixels; DRAIN records that the run request
    // was withdrawn and the current frame is only being finished.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [9:0]  r_hCount;        // column of the next pixel to emit
    logic [9:0]  r_vCount;        // line of the next pixel to emit
    logic        r_hRequest;
    logic        r_vRequest;
    logic        r_request;
    logic [19:0] r_pixelAddress;
    logic        r_hSync_n;
    logic        r_vSync_n;
    logic        r_lineStart;
    logic        r_frameStart;
    logic        r_running;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic        w_emit;
    logic        w_lastCol;
    logic        w_lastRow;
    logic        w_lastPixel;
    logic [9:0]  w_nextH;
    logic [9:0]  w_nextV;
    logic        w_hActive;
    logic        w_vActive;
    logic        w_hSyncPulse;
    logic        w_vSyncPulse;
    logic [9:0]  w_addrH;
    logic [9:0]  w_addrV;
    logic        w_addrInActive;
    logic [19:0] w_pixelAddress;
    state_t      w_runState;

    // A pixel is emitted on every clock of a frame. From IDLE the very clock
    // that sees iEnable already emits pixel (0,0): the counters sit at 0,0
    // while idle, so no warm-up cycle is needed.
    assign w_emit      = (r_state != IDLE) || iEnable;

    assign w_lastCol   = (r_hCount == c_hLast);
    assign w_lastRow   = (r_vCount == c_vLast);
    assign w_lastPixel = w_lastCol && w_lastRow;

    always_comb begin
        w_nextH = r_hCount + 10'd1;
        w_nextV = r_vCount;
        if (w_lastCol) begin
            w_nextH = 10'd0;
            w_nextV = w_lastRow ? 10'd0 : (r_vCount + 10'd1);
        end
    end

    assign w_hActive    = (r_hCount < c_hActive);
    assign w_vActive    = (r_vCount < c_vActive);
    assign w_hSyncPulse = (r_hCount >= c_hSyncBeg) && (r_hCount < c_hSyncEnd);
    assign w_vSyncPulse = (r_vCount >= c_vSyncBeg) && (r_vCount < c_vSyncEnd);

`ifdef VGA_REQ_ADDR_LEAD_EN
    // Address the pixel that follows the one being emitted. After the last
    // pixel of a frame the successor is (0,0), whose address is 0 anyway.
    assign w_addrH = w_nextH;
    assign w_addrV = w_nextV;
`else
    assign w_addrH = r_hCount;
    assign w_addrV = r_vCount;
`endif

    // Out-of-area addresses are forced to 0 so the RAM never sees a value
    // beyond {V_ACTIVE-1, H_ACTIVE-1}.
    assign w_addrInActive = (w_addrH < c_hActive) && (w_addrV < c_vActive);
    assign w_pixelAddress = w_addrInActive ? {w_addrV, w_addrH} : 20'd0;

    // iEnable only matters for the frame boundary decision; mid-frame it
    // just selects RUN vs DRAIN, both of which keep emitting.
    always_comb begin
        w_runState = iEnable ? RUN : DRAIN;
        if (w_lastPixel && !iEnable) begin
            w_runState = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge iVgaClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state        <= IDLE;
            r_hCount       <= 10'd0;
            r_vCount       <= 10'd0;
            r_hRequest     <= 1'b0;
            r_vRequest     <= 1'b0;
            r_request      <= 1'b0;
            r_pixelAddress <= 20'd0;
            r_hSync_n      <= 1'b1;
            r_vSync_n      <= 1'b1;
            r_lineStart    <= 1'b0;
            r_frameStart   <= 1'b0;
            r_running      <= 1'b0;
        end else if (w_emit) begin
            r_state        <= w_runState;
            r_hCount       <= w_nextH;
            r_vCount       <= w_nextV;
            r_hRequest     <= w_hActive;
            r_vRequest     <= w_vActive;
            r_request      <= w_hActive && w_vActive;
            r_pixelAddress <= w_pixelAddress;
            r_hSync_n      <= ~w_hSyncPulse;
            r_vSync_n      <= ~w_vSyncPulse;
            r_lineStart    <= (r_hCount == 10'd0) && w_vActive;
            r_frameStart   <= (r_hCount == 10'd0) && (r_vCount == 10'd0);
            r_running      <= 1'b1;
        end else begin
            // Idle: counters stay parked at 0,0, outputs quiescent.
            r_state        <= IDLE;
            r_hRequest     <= 1'b0;
            r_vRequest     <= 1'b0;
            r_request      <= 1'b0;
            r_pixelAddress <= 20'd0;
            r_hSync_n      <= 1'b1;
            r_vSync_n      <= 1'b1;
            r_lineStart    <= 1'b0;
            r_frameStart   <= 1'b0;
            r_running      <= 1'b0;
        end
    end

    assign oVgaHRequest  = r_hRequest;
    assign oVgaVRequest  = r_vRequest;
    assign oVgaRequest   = r_request;
    assign oPixelAddress = r_pixelAddress;
    assign oVgaHS_n      = r_hSync_n;
    assign oVgaVS_n      = r_vSync_n;
    assign oLineStart    = r_lineStart;
    assign oFrameStart   = r_frameStart;
    assign oRunning      = r_running;

endmodule
`default_nettype wire

// File: tb/tb_vga_request_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_request_gen
// Description : Scoreboard bench for vga_request_gen. Two instances share the
//               stimulus: a shrunken geometry that completes many frames, and
//               the default 640x480 geometry that covers the first lines.
//               A reference model walks a linear pixel index per frame and
//               pushes the expected outputs; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_request_gen;

    localparam int HA0 = 16, HF0 = 2, HS0 = 4, HB0 = 3;
    localparam int VA0 = 6,  VF0 = 1, VS0 = 2, VB0 = 2;
    localparam int HT0 = HA0 + HF0 + HS0 + HB0;
    localparam int VT0 = VA0 + VF0 + VS0 + VB0;
    localparam int TOT0 = HT0 * VT0;

    typedef struct packed {
        logic        hReq;
        logic        vReq;
        logic        req;
        logic [19:0] addr;
        logic        hsN;
        logic        vsN;
        logic        lineSt;
        logic        frameSt;
        logic        running;
    } obs_t;

    logic clk = 1'b0;
    logic rstN = 1'b1;
    logic enable = 1'b0;
    bit   scoreOn = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    logic        hReq0, vReq0, req0, hsN0, vsN0, ls0, fs0, run0;
    logic        hReq1, vReq1, req1, hsN1, vsN1, ls1, fs1, run1;
    logic [19:0] addr0, addr1;
    obs_t        got0, got1;

    assign got0 = {hReq0, vReq0, req0, addr0, hsN0, vsN0, ls0, fs0, run0};
    assign got1 = {hReq1, vReq1, req1, addr1, hsN1, vsN1, ls1, fs1, run1};

    vga_request_gen #(
        .H_ACTIVE(HA0), .H_FP(HF0), .H_SYNC(HS0), .H_BP(HB0),
        .V_ACTIVE(VA0), .V_FP(VF0), .V_SYNC(VS0), .V_BP(VB0)
    ) dut0 (
        .iVgaClk(clk), .iReset_n(rstN), .iEnable(enable),
        .oVgaHRequest(hReq0), .oVgaVRequest(vReq0), .oVgaRequest(req0),
        .oPixelAddress(addr0), .oVgaHS_n(hsN0), .oVgaVS_n(vsN0),
        .oLineStart(ls0), .oFrameStart(fs0), .oRunning(run0)
    );

    vga_request_gen dut1 (
        .iVgaClk(clk), .iReset_n(rstN), .iEnable(enable),
        .oVgaHRequest(hReq1), .oVgaVRequest(vReq1), .oVgaRequest(req1),
        .oPixelAddress(addr1), .oVgaHS_n(hsN1), .oVgaVS_n(vsN1),
        .oLineStart(ls1), .oFrameStart(fs1), .oRunning(run1)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic obs_t idleObs();
        obs_t o;
        o = '0;
        o.hsN = 1'b1;
        o.vsN = 1'b1;
        return o;
    endfunction

    function automatic int totalOf(input int g);
        return (g == 0) ? TOT0 : 800 * 525;
    endfunction

    // Expected outputs for linear pixel index p of a frame.
    function automatic obs_t pixelObs(input int g, input int p);
        int ha, hf, hs, ht, va, vf, vs, vt;
        int h, v, nh, nv, n;
        obs_t o;
        if (g == 0) begin
            ha = HA0; hf = HF0; hs = HS0; ht = HT0;
            va = VA0; vf = VF0; vs = VS0; vt = VT0;
        end else begin
            ha = 640; hf = 16; hs = 96; ht = 800;
            va = 480; vf = 10; vs = 2;  vt = 525;
        end
        h = p % ht;
        v = p / ht;
        o.hReq    = (h < ha);
        o.vReq    = (v < va);
        o.req     = (h < ha) && (v < va);
        o.hsN     = !((h >= ha + hf) && (h < ha + hf + hs));
        o.vsN     = !((v >= va + vf) && (v < va + vf + vs));
        o.lineSt  = (h == 0) && (v < va);
        o.frameSt = (p == 0);
        o.running = 1'b1;
`ifdef VGA_REQ_ADDR_LEAD_EN
        n  = (p + 1) % (ht * vt);
        nh = n % ht;
        nv = n / ht;
`else
        n  = p;
        nh = h;
        nv = v;
`endif
        o.addr = ((nh < ha) && (nv < va)) ? {10'(nv), 10'(nh)} : 20'd0;
        return o;
    endfunction

    // One clock of the model: a frame starts when enabled while idle, and
    // at the end of each frame the enable decides whether another follows.
    task automatic advance(input int g, input bit en, inout bit act,
                           inout int pos, output obs_t o);
        if (!act && en) begin
            act = 1'b1;
            pos = 0;
        end
        if (act) begin
            o = pixelObs(g, pos);
            pos = pos + 1;
            if (pos == totalOf(g)) begin
                pos = 0;
                act = en;
            end
        end else begin
            o = idleObs();
        end
    endtask

    obs_t q0[$];
    obs_t q1[$];
    bit   act0 = 1'b0, act1 = 1'b0;
    int   pos0 = 0, pos1 = 0;

    initial begin
        obs_t e0, e1;
        forever begin
            @(posedge clk or negedge rstN);
            if (!rstN) begin
                act0 = 1'b0; pos0 = 0;
                act1 = 1'b0; pos1 = 0;
                q0.delete();
                q1.delete();
                q0.push_back(idleObs());
                q1.push_back(idleObs());
            end else begin
                advance(0, enable, act0, pos0, e0);
                advance(1, enable, act1, pos1, e1);
                q0.push_back(e0);
                q1.push_back(e1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (scoreOn) begin
                total++;
                if (q0.size() == 0) begin
                    bad++;
                    $display("FAIL sb0 t=%0t no expected entry, got=%h", $time, got0);
                end else begin
                    e = q0.pop_front();
                    if (got0 !== e) begin
                        bad++;
                        $display("FAIL sb0 t=%0t got=%h exp=%h", $time, got0, e);
                    end
                end
                total++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL sb1 t=%0t no expected entry, got=%h", $time, got1);
                end else begin
                    e = q1.pop_front();
                    if (got1 !== e) begin
                        bad++;
                        $display("FAIL sb1 t=%0t got=%h exp=%h", $time, got1, e);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ------------------------------------------------------------------
    // Directed checks
    // ------------------------------------------------------------------
    task automatic chk(input string name, input int gotV, input int expV);
        total++;
        if (gotV !== expV) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, gotV, expV);
        end
    endtask

    task automatic timeoutFail(input string name);
        total++;
        bad++;
        $display("FAIL %s timeout waiting for DUT event", name);
    endtask

    task automatic waitFrameStart(input string name, output int c, output bit ok);
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < 2 * TOT0 + 8; i++) begin
            @(negedge clk);
            if (fs0 === 1'b1) begin
                c  = cyc;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeoutFail(name);
    endtask

    initial begin
        int c0, c1, reqCnt, lsCnt, hsLow, vsLow, r;
        bit ok;

        // Reset with enable already requested.
        @(posedge clk); #2;
        rstN = 1'b0; enable = 1'b1; scoreOn = 1'b1;
        repeat (5) @(posedge clk);
        #2 rstN = 1'b1;
        @(negedge clk);
        chk("resetRunning", int'(run0), 0);
        chk("resetHsN", int'(hsN0), 1);
        @(negedge clk);
        chk("firstFrameStart", int'(fs0), 1);
        chk("firstLineStart", int'(ls0), 1);
        chk("firstRequest", int'(req0), 1);

        // One full frame of counts, then the next frame must follow at once.
        reqCnt = int'(req0); lsCnt = int'(ls0);
        hsLow = int'(!hsN0); vsLow = int'(!vsN0);
        for (int i = 1; i < TOT0; i++) begin
            @(negedge clk);
            reqCnt += int'(req0);
            lsCnt  += int'(ls0);
            hsLow  += int'(!hsN0);
            vsLow  += int'(!vsN0);
        end
        chk("frameRequestCount", reqCnt, HA0 * VA0);
        chk("frameLineStarts", lsCnt, VA0);
        chk("frameHsLowClocks", hsLow, HS0 * VT0);
        chk("frameVsLowClocks", vsLow, VS0 * HT0);
        @(negedge clk);
        chk("backToBackFrameStart", int'(fs0), 1);

        // Random enable toggling.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 99) < 2) enable = ~enable;
        end

        // Withdraw enable on line 2: the frame finishes, then idle.
        @(posedge clk); #2 enable = 1'b1;
        waitFrameStart("drainStart", c0, ok);
        repeat (2 * HT0) @(posedge clk);
        #2 enable = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2 * TOT0; i++) begin
            @(negedge clk);
            if (run0 === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) chk("drainFrameLength", cyc - c0, TOT0);
        else timeoutFail("drainEnd");
        repeat (3) begin
            @(negedge clk);
            chk("idleStaysIdle", int'(run0), 0);
        end
        @(posedge clk); #2 enable = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("restartFrameStart", int'(fs0), 1);
        c0 = cyc;

        // Drop and restore enable inside one frame: no gap between frames.
        repeat (50) @(posedge clk);
        #2 enable = 1'b0;
        repeat (40) @(posedge clk);
        #2 enable = 1'b1;
        waitFrameStart("drainRunStart", c1, ok);
        if (ok) chk("drainRunPeriod", c1 - c0, TOT0);

        // Reset mid-frame: outputs go idle within the same clock.
        repeat (3 * HT0 + 5) @(posedge clk);
        #2 rstN = 1'b0;
        @(negedge clk);
        chk("midResetRunning0", int'(run0), 0);
        chk("midResetRunning1", int'(run1), 0);
        chk("midResetHsN", int'(hsN0), 1);
        repeat (3) @(posedge clk);
        #2 rstN = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("postResetFrameStart", int'(fs0), 1);

        // Random enable plus occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            r = int'($urandom_range(0, 999));
            if (!rstN) begin
                if (r < 500) rstN = 1'b1;
            end else if (r < 20) begin
                enable = ~enable;
            end else if (r < 23) begin
                rstN = 1'b0;
            end
        end

        @(negedge clk);
        #1;
        scoreOn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
